// File: rtl/filter_sched_pkg.sv
// ============================================================================
// Module      : filter_sched_pkg
// Description : Shared types and helpers for the filter schedule controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package filter_sched_pkg;

  typedef enum logic [1:0] {
    MANUAL  = 2'd0,
    AUDIO   = 2'd1,
    LOCKOUT = 2'd2
  } sched_state_t;

  typedef logic [1:0] filter_code_t;

  localparam filter_code_t FILTER_NONE = 2'd0;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/filter_schedule_ctrl_tone.sv
// ============================================================================
// Module      : tone_stability_detector
// Description : Accepts a pitch flag only after STABLE_COUNT identical samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_stability_detector
  import filter_sched_pkg::*;
#(
  parameter int STABLE_COUNT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  filter_code_t freq_flag,
  input  logic         freq_valid,
  output logic         tone_stable,
  output filter_code_t cand
);

  localparam int CNT_W = cnt_width(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  filter_code_t     cand_q, cand_d;
  logic             stable_q, stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    if (clear) begin
      cnt_d  = '0;
      cand_d = FILTER_NONE;
    end else if (freq_valid) begin
      if (freq_flag == cand_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cand_d = freq_flag;
        cnt_d  = CNT_W'(1);
      end
    end
    // A silent flag can saturate the count but never reports a tone.
    stable_d = (cnt_d == CNT_MAX) && (cand_d != FILTER_NONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      cand_q   <= FILTER_NONE;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
    end
  end

  assign tone_stable = stable_q;
  assign cand        = cand_q;

endmodule

`default_nettype wire

// File: rtl/filter_schedule_ctrl.sv
// ============================================================================
// Module      : filter_schedule_ctrl
// Description : Arbitrates manual and audio filter selection, commits on frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_schedule_ctrl
  import filter_sched_pkg::*;
#(
  parameter int STABLE_COUNT   = 8,
  parameter int HOLD_FRAMES    = 60,
  parameter int LOCKOUT_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       auto_en,
  input  logic [1:0] manual_filter,
  input  logic [1:0] freq_flag,
  input  logic       freq_valid,
  input  logic       sop_in,
  input  logic       ready_in,
  output logic [1:0] filter_num,
  output logic [1:0] mode,
  output logic       filter_changed,
  output logic       audio_active
);

  localparam int HOLD_W = cnt_width(HOLD_FRAMES);
  localparam int LOCK_W = cnt_width(LOCKOUT_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [LOCK_W-1:0] LOCK_RELOAD = LOCK_W'(LOCKOUT_FRAMES - 1);

  sched_state_t      state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  filter_code_t      target_q, target_d;
  filter_code_t      manual_q;
  filter_code_t      filter_num_q, filter_num_d;
  logic              changed_q, changed_d;

  logic         frame_tick;
  logic         man_chg;
  logic         tone_stable;
  filter_code_t cand;
  filter_code_t pending;

  assign frame_tick = sop_in & ready_in;
  assign man_chg    = (manual_filter != manual_q);

  tone_stability_detector #(
    .STABLE_COUNT (STABLE_COUNT)
  ) u_tone_det (
    .clk         (clk),
    .reset       (reset),
    .clear       (state_q == LOCKOUT),
    .freq_flag   (freq_flag),
    .freq_valid  (freq_valid),
    .tone_stable (tone_stable),
    .cand        (cand)
  );

  // Pending filter comes from the pre-transition state so a frame never mixes.
  assign pending = (state_q == AUDIO) ? target_q : manual_filter;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    lock_d   = lock_q;
    target_d = target_q;
    case (state_q)
      MANUAL: begin
        if (auto_en && man_chg) begin
          state_d = LOCKOUT;
          lock_d  = LOCK_RELOAD;
        end else if (auto_en && tone_stable) begin
          state_d  = AUDIO;
          target_d = cand;
          hold_d   = HOLD_RELOAD;
        end
      end
      AUDIO: begin
        if (!auto_en) begin
          state_d = MANUAL;
        end else if (man_chg) begin
          state_d = LOCKOUT;
          lock_d  = LOCK_RELOAD;
        end else if (tone_stable) begin
          target_d = cand;
          hold_d   = HOLD_RELOAD;
        end else if (frame_tick) begin
          if (hold_q == '0) state_d = MANUAL;
          else              hold_d  = hold_q - HOLD_W'(1);
        end
      end
      LOCKOUT: begin
        if (!auto_en) begin
          state_d = MANUAL;
        end else if (man_chg) begin
          lock_d = LOCK_RELOAD;
        end else if (frame_tick) begin
          if (lock_q == '0) state_d = MANUAL;
          else              lock_d  = lock_q - LOCK_W'(1);
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  always_comb begin
    filter_num_d = filter_num_q;
    changed_d    = 1'b0;
    if (frame_tick) begin
      filter_num_d = pending;
      changed_d    = (pending != filter_num_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= MANUAL;
      hold_q       <= '0;
      lock_q       <= '0;
      target_q     <= FILTER_NONE;
      manual_q     <= FILTER_NONE;
      filter_num_q <= FILTER_NONE;
      changed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      lock_q       <= lock_d;
      target_q     <= target_d;
      manual_q     <= manual_filter;
      filter_num_q <= filter_num_d;
      changed_q    <= changed_d;
    end
  end

  assign filter_num     = filter_num_q;
  assign mode           = state_q;
  assign filter_changed = changed_q;
  assign audio_active   = (state_q == AUDIO);

endmodule

`default_nettype wire

// File: tb/tb_filter_schedule_ctrl.sv
// ============================================================================
// Module      : tb_filter_schedule_ctrl
// Description : Directed self-checking bench for filter_schedule_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filter_schedule_ctrl;

  logic       clk;
  logic       reset;
  logic       auto_en;
  logic [1:0] manual_filter;
  logic [1:0] freq_flag;
  logic       freq_valid;
  logic       sop_in;
  logic       ready_in;
  logic [1:0] filter_num;
  logic [1:0] mode;
  logic       filter_changed;
  logic       audio_active;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  int p0;

  filter_schedule_ctrl #(
    .STABLE_COUNT   (4),
    .HOLD_FRAMES    (3),
    .LOCKOUT_FRAMES (5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .auto_en        (auto_en),
    .manual_filter  (manual_filter),
    .freq_flag      (freq_flag),
    .freq_valid     (freq_valid),
    .sop_in         (sop_in),
    .ready_in       (ready_in),
    .filter_num     (filter_num),
    .mode           (mode),
    .filter_changed (filter_changed),
    .audio_active   (audio_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each one-cycle pulse is counted exactly once on the falling edge.
  always @(negedge clk) if (filter_changed === 1'b1) pulse_cnt++;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    else n_pass++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_sop();
    sop_in = 1'b1;
    @(posedge clk);
    #1;
    sop_in = 1'b0;
    cycles(99);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; auto_en = 1'b1; manual_filter = 2'd0; freq_flag = 2'd0;
    freq_valid = 1'b1; sop_in = 1'b0; ready_in = 1'b1;
    cycles(3);
    check_eq("rst_fn", filter_num, 0);
    check_eq("rst_mode", mode, 0);
    check_eq("rst_chg", filter_changed, 0);
    check_eq("rst_audio", audio_active, 0);
    reset = 1'b0;
    cycles(5);
    p0 = pulse_cnt; do_sop();
    check_eq("idle_fn", filter_num, 0);
    check_eq("idle_pulse", pulse_cnt - p0, 0);

    // Manual change enters lockout and commits on the next frame
    manual_filter = 2'd2; cycles(1);
    check_eq("man_lockout", mode, 2);
    check_eq("man_no_early", filter_num, 0);
    p0 = pulse_cnt; do_sop();
    check_eq("man_fn", filter_num, 2);
    check_eq("man_pulse", pulse_cnt - p0, 1);
    do_sop(); do_sop(); do_sop();
    check_eq("lock_hold", mode, 2);
    do_sop();
    check_eq("lock_exit", mode, 0);
    check_eq("lock_exit_fn", filter_num, 2);
    check_eq("lock_pulses", pulse_cnt - p0, 1);

    // Three samples of a tone are not enough
    freq_flag = 2'd3; cycles(3); freq_flag = 2'd0; cycles(10);
    check_eq("short_tone", mode, 0);

    // Four or more samples are accepted
    freq_flag = 2'd3; cycles(10);
    check_eq("acc_mode", mode, 1);
    check_eq("acc_audio", audio_active, 1);
    check_eq("acc_no_early", filter_num, 2);
    freq_flag = 2'd0; cycles(5);
    p0 = pulse_cnt; do_sop();
    check_eq("acc_fn", filter_num, 3);
    check_eq("acc_pulse", pulse_cnt - p0, 1);
    check_eq("hold1_mode", mode, 1);
    do_sop();
    check_eq("hold2_fn", filter_num, 3);
    check_eq("hold2_mode", mode, 1);
    do_sop();
    check_eq("hold3_fn", filter_num, 3);
    check_eq("hold_exit", mode, 0);
    p0 = pulse_cnt; do_sop();
    check_eq("revert_fn", filter_num, 2);
    check_eq("revert_pulse", pulse_cnt - p0, 1);

    // Manual change in the cycle the tone becomes stable wins
    freq_flag = 2'd1; cycles(4);
    manual_filter = 2'd1; cycles(1);
    check_eq("prio_mode", mode, 2);
    check_eq("prio_audio", audio_active, 0);
    p0 = pulse_cnt; do_sop();
    check_eq("prio_fn", filter_num, 1);
    check_eq("prio_pulse", pulse_cnt - p0, 1);
    do_sop(); do_sop(); do_sop();
    check_eq("lock_ignore_tone", mode, 2);
    freq_flag = 2'd0; cycles(1);
    do_sop();
    check_eq("prio_exit", mode, 0);

    // Backpressured frames neither commit nor count
    freq_flag = 2'd2; cycles(10);
    check_eq("bp_audio", mode, 1);
    freq_flag = 2'd0; cycles(3);
    ready_in = 1'b0; p0 = pulse_cnt;
    do_sop(); do_sop(); do_sop();
    ready_in = 1'b1;
    check_eq("bp_fn", filter_num, 1);
    check_eq("bp_pulse", pulse_cnt - p0, 0);
    check_eq("bp_no_count", mode, 1);
    p0 = pulse_cnt; do_sop();
    check_eq("bp_commit_fn", filter_num, 2);
    check_eq("bp_commit_pulse", pulse_cnt - p0, 1);
    check_eq("bp_still_audio", mode, 1);

    // Disabling audio arbitration returns to manual at once
    auto_en = 1'b0; cycles(1);
    check_eq("auto_off_mode", mode, 0);
    check_eq("auto_off_fn", filter_num, 2);
    p0 = pulse_cnt; do_sop();
    check_eq("auto_off_commit", filter_num, 1);
    check_eq("auto_off_pulse", pulse_cnt - p0, 1);

    // Reset mid-stream overrides an active frame start
    auto_en = 1'b1; p0 = pulse_cnt;
    manual_filter = 2'd0; reset = 1'b1; sop_in = 1'b1;
    cycles(2);
    check_eq("mrst_fn", filter_num, 0);
    check_eq("mrst_mode", mode, 0);
    reset = 1'b0; sop_in = 1'b0;
    cycles(1);
    check_eq("mrst_chg", filter_changed, 0);
    check_eq("mrst_pulse", pulse_cnt - p0, 0);
    check_eq("mrst_mode_after", mode, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
